// File: rtl/alu_op_encode_pkg.sv
// Shared opcode constants, one-hot request bit positions and FSM state encoding
// for the execute-stage ALU opcode encoder and its matching decoder.
package alu_op_encode_pkg;

  localparam int OP_W = 5;
  localparam int OH_W = 8;

  localparam logic [OP_W-1:0] OP_ADD = 5'b00000;
  localparam logic [OP_W-1:0] OP_SUB = 5'b00001;
  localparam logic [OP_W-1:0] OP_AND = 5'b00010;
  localparam logic [OP_W-1:0] OP_OR  = 5'b00011;
  localparam logic [OP_W-1:0] OP_SLL = 5'b00100;
  localparam logic [OP_W-1:0] OP_SRA = 5'b00101;
  localparam logic [OP_W-1:0] OP_MUL = 5'b00110;
  localparam logic [OP_W-1:0] OP_DIV = 5'b00111;

  localparam int OH_ADD = 0;
  localparam int OH_SUB = 1;
  localparam int OH_AND = 2;
  localparam int OH_OR  = 3;
  localparam int OH_SLL = 4;
  localparam int OH_SRA = 5;
  localparam int OH_MUL = 6;
  localparam int OH_DIV = 7;

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_WAIT_MD = 1'b1
  } state_t;

  // Opcode for a request whose only set bit is at position idx.
  function automatic logic [OP_W-1:0] oh_bit_to_op(input int idx);
    logic [OP_W-1:0] code;
    case (idx)
      OH_ADD:  code = OP_ADD;
      OH_SUB:  code = OP_SUB;
      OH_AND:  code = OP_AND;
      OH_OR:   code = OP_OR;
      OH_SLL:  code = OP_SLL;
      OH_SRA:  code = OP_SRA;
      OH_MUL:  code = OP_MUL;
      default: code = OP_DIV;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/alu_op_encode_onehot_to_opcode.sv
// Combinational one-hot request to ALU opcode encoder; flags multdiv requests
// and whether the request has exactly one bit set.
module onehot_to_opcode
  import alu_op_encode_pkg::*;
(
  input  logic [OH_W-1:0] op_onehot,
  output logic [OP_W-1:0] code,
  output logic            is_md,
  output logic            onehot_ok
);

  logic [OP_W-1:0] w_code_terms [OH_W];
  logic [OH_W-1:0] w_minus_one;

  genvar gi;
  generate
    for (gi = 0; gi < OH_W; gi++) begin : g_terms
      assign w_code_terms[gi] = op_onehot[gi] ? oh_bit_to_op(gi) : '0;
    end
  endgenerate

  // OR of the per-bit codes is only meaningful when onehot_ok is set.
  always_comb begin
    code = '0;
    for (int i = 0; i < OH_W; i++) begin
      code = code | w_code_terms[i];
    end
  end

  assign w_minus_one = op_onehot - OH_W'(1);
  assign onehot_ok   = (op_onehot != '0) && ((op_onehot & w_minus_one) == '0);
  assign is_md       = onehot_ok && (op_onehot[OH_MUL] || op_onehot[OH_DIV]);

endmodule

// File: rtl/alu_op_encode.sv
// Issue-side ALU opcode encoder: registers the opcode for a one-hot request,
// starts the multdiv unit and stalls new requests until it completes or times out.
module alu_op_encode
  import alu_op_encode_pkg::*;
#(
  parameter int MD_TIMEOUT = 40,
  parameter int CNT_W      = 6
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            op_valid,
  input  logic [OH_W-1:0] op_onehot,
  output logic            op_ready,
  input  logic            md_result_rdy,
  output logic [OP_W-1:0] ctrl_ALUopcode,
  output logic            alu_issue,
  output logic            ctrl_MULT,
  output logic            ctrl_DIV,
  output logic            busy,
  output logic            err_illegal,
  output logic            md_timeout
);

  state_t          r_state, r_state_next;
  logic [CNT_W-1:0] r_cnt, r_cnt_next;
  logic [OP_W-1:0] r_opcode, r_opcode_next;
  logic            r_issue, r_issue_next;
  logic            r_mult, r_mult_next;
  logic            r_div, r_div_next;
  logic            r_err, r_err_next;
  logic            r_tmo, r_tmo_next;

  logic [OP_W-1:0] w_code;
  logic            w_is_md;
  logic            w_onehot_ok;

  onehot_to_opcode u_enc (
    .op_onehot (op_onehot),
    .code      (w_code),
    .is_md     (w_is_md),
    .onehot_ok (w_onehot_ok)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_opcode <= '0;
      r_issue  <= 1'b0;
      r_mult   <= 1'b0;
      r_div    <= 1'b0;
      r_err    <= 1'b0;
      r_tmo    <= 1'b0;
    end else begin
      r_state  <= r_state_next;
      r_cnt    <= r_cnt_next;
      r_opcode <= r_opcode_next;
      r_issue  <= r_issue_next;
      r_mult   <= r_mult_next;
      r_div    <= r_div_next;
      r_err    <= r_err_next;
      r_tmo    <= r_tmo_next;
    end
  end

  always_comb begin
    r_state_next  = r_state;
    r_cnt_next    = r_cnt;
    r_opcode_next = r_opcode;
    r_issue_next  = 1'b0;
    r_mult_next   = 1'b0;
    r_div_next    = 1'b0;
    r_err_next    = 1'b0;
    r_tmo_next    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (op_valid) begin
          if (w_onehot_ok) begin
            r_opcode_next = w_code;
            r_issue_next  = 1'b1;
            if (w_is_md) begin
              r_mult_next  = op_onehot[OH_MUL];
              r_div_next   = op_onehot[OH_DIV];
              r_state_next = S_WAIT_MD;
              r_cnt_next   = '0;
            end
          end else begin
            r_err_next = 1'b1;
          end
        end
      end
      S_WAIT_MD: begin
        // A result arriving on the expiry cycle takes priority over the timeout.
        if (md_result_rdy) begin
          r_state_next = S_IDLE;
          r_cnt_next   = '0;
        end else if (r_cnt == CNT_W'(MD_TIMEOUT - 1)) begin
          r_tmo_next   = 1'b1;
          r_state_next = S_IDLE;
          r_cnt_next   = '0;
        end else begin
          r_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        r_state_next = S_IDLE;
        r_cnt_next   = '0;
      end
    endcase
  end

  assign op_ready       = (r_state == S_IDLE);
  assign busy           = (r_state == S_WAIT_MD);
  assign ctrl_ALUopcode = r_opcode;
  assign alu_issue      = r_issue;
  assign ctrl_MULT      = r_mult;
  assign ctrl_DIV       = r_div;
  assign err_illegal    = r_err;
  assign md_timeout     = r_tmo;

endmodule
